// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Purpose  : IF/ID instruction queue buffering {pc+4, instruction} pairs from
//            fetch and presenting the oldest to decode under valid/ready.
//            Optional macro IFQ_BYPASS_EN adds a same-cycle empty-queue bypass.
// Revision : 1.0  initial release
// ============================================================================
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hit,
    input  logic [DATA_W-1:0] next_pc,
    input  logic [DATA_W-1:0] instruction,
    output logic              full,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instruction,
    output logic [DATA_W-1:0] id_next_pc,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  instr_mem_q [DEPTH];
    logic [DATA_W-1:0]  pc_mem_q    [DEPTH];

    logic head_valid;
    logic bypass;
    logic push;
    logic pop;

    // Bypass hands the incoming word straight to decode; it is never stored.
`ifdef IFQ_BYPASS_EN
    assign bypass = (state_q == S_EMPTY) & hit & ~flush & id_ready & ~rst;
`else
    assign bypass = 1'b0;
`endif

    assign full       = (count_q == CNT_FULL);
    assign head_valid = (count_q != '0);
    assign push       = hit & ~full & ~flush & ~bypass;
    assign pop        = head_valid & id_ready & ~flush;
    assign count      = count_q;

    always_comb begin
        id_valid       = 1'b0;
        id_instruction = '0;
        id_next_pc     = '0;
        if (bypass) begin
            id_valid       = 1'b1;
            id_instruction = instruction;
            id_next_pc     = next_pc;
        end else if (head_valid) begin
            id_valid       = 1'b1;
            id_instruction = instr_mem_q[rd_ptr_q];
            id_next_pc     = pc_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            state_d  = S_EMPTY;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        count_d = CNT_ONE;
                        state_d = (CNT_ONE == CNT_FULL) ? S_FULL : S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (push && !pop) begin
                        count_d = count_q + 1'b1;
                        if (count_q == CNT_LAST) state_d = S_FULL;
                    end else if (pop && !push) begin
                        count_d = count_q - 1'b1;
                        if (count_q == CNT_ONE) state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // A full queue never accepts, even when decode pops this cycle.
                    if (pop) begin
                        count_d = count_q - 1'b1;
                        state_d = S_PARTIAL;
                    end
                end
                default: begin
                    state_d  = S_EMPTY;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem_q[wr_ptr_q] <= instruction;
            pc_mem_q[wr_ptr_q]    <= next_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Purpose  : Self-checking bench for if_id_queue against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        hit = 1'b0;
    logic [31:0] next_pc = '0;
    logic [31:0] instruction = '0;
    logic        full;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_next_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];

    if_id_queue #(.DEPTH(4), .PTR_W(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hit(hit),
        .next_pc(next_pc), .instruction(instruction), .full(full),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instruction(id_instruction), .id_next_pc(id_next_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_bypass();
`ifdef IFQ_BYPASS_EN
        return !rst && !flush && hit && id_ready && (mq.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Compare DUT against the model for the currently driven inputs.
    task automatic compare();
        bit          byp;
        logic [31:0] ei, ep;
        byp = model_bypass();
        ei = '0;
        ep = '0;
        if (byp) begin
            ei = instruction;
            ep = next_pc;
        end else if (mq.size() > 0) begin
            ei = mq[0][31:0];
            ep = mq[0][63:32];
        end
        chk("m_valid", {31'b0, id_valid}, {31'b0, byp || mq.size() > 0});
        chk("m_instr", id_instruction, ei);
        chk("m_pc", id_next_pc, ep);
        chk("m_count", {29'b0, count}, 32'(mq.size()));
        chk("m_full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    endtask

    task automatic model_edge();
        bit byp, do_pop, do_push;
        byp = model_bypass();
        if (rst || flush) begin
            mq.delete();
        end else if (!byp) begin
            do_pop  = (mq.size() > 0) && id_ready;
            do_push = hit && (mq.size() < DEPTH);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({next_pc, instruction});
        end
    endtask

    // Drive one cycle: inputs set in the low phase, checked, then clocked.
    task automatic step(input logic r, input logic f, input logic h,
                        input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        rst = r; flush = f; hit = h; next_pc = pc; instruction = ins; id_ready = rdy;
        #1;
        compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; flush = 0; hit = 0; id_ready = 0;
        #1;
    endtask

    initial begin
        @(negedge clk);
        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        quiet();
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instruction, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);

        // Single push, one-cycle latency
        step(0, 0, 1, 32'h4, 32'h2008_0005, 0);
        quiet();
        chk("lat_valid", {31'b0, id_valid}, 32'd1);
        chk("lat_instr", id_instruction, 32'h2008_0005);
        chk("lat_pc", id_next_pc, 32'h4);
        chk("lat_count", {29'b0, count}, 32'd1);

        // Fill to full, fifth word dropped, drain in order
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1, 32'(i * 4), 32'(i), 0);
            if (i == 4) begin
                chk("fill_full", {31'b0, full}, 32'd1);
                chk("fill_count", {29'b0, count}, 32'd4);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            quiet();
            chk("drain_order", id_instruction, 32'(i));
            step(0, 0, 0, 0, 0, 1);
        end
        quiet();
        chk("drain_empty", {31'b0, id_valid}, 32'd0);

        // Steady push+pop at count 2, pointers wrap
        step(0, 0, 1, 32'hA4, 32'hA, 0);
        step(0, 0, 1, 32'hB4, 32'hB, 0);
        for (int i = 0; i < 3; i++) begin
            quiet();
            chk("wrap_head", id_instruction, 32'hA + 32'(i));
            step(0, 0, 1, 32'hC4 + 32'(i * 16), 32'hC + 32'(i), 1);
            chk("wrap_count", {29'b0, count}, 32'd2);
        end
        quiet();
        chk("wrap_next", id_instruction, 32'hD);

        // Flush with hit discards the wrong-path word
        step(0, 0, 1, 32'hF4, 32'hF, 0);
        step(0, 1, 1, 32'hDEAD, 32'hBAD, 0);
        quiet();
        chk("fl_count", {29'b0, count}, 32'd0);
        chk("fl_valid", {31'b0, id_valid}, 32'd0);
        chk("fl_full", {31'b0, full}, 32'd0);
        step(0, 0, 1, 32'h78, 32'h77, 0);
        quiet();
        chk("fl_after", id_instruction, 32'h77);

        // Empty-queue word with decode ready
        step(1, 0, 0, 0, 0, 0);
        rst = 0; flush = 0; hit = 1; next_pc = 32'h24; instruction = 32'h20; id_ready = 1;
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_same_valid", {31'b0, id_valid}, 32'd1);
        chk("byp_same_instr", id_instruction, 32'h20);
`else
        chk("byp_same_valid", {31'b0, id_valid}, 32'd0);
`endif
        step(0, 0, 1, 32'h24, 32'h20, 1);
        quiet();
`ifdef IFQ_BYPASS_EN
        chk("byp_next_count", {29'b0, count}, 32'd0);
`else
        chk("byp_next_valid", {31'b0, id_valid}, 32'd1);
        chk("byp_next_instr", id_instruction, 32'h20);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom, $urandom,
                 $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
